instr_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the single-cycle CPU.
- Accepts a byte stream over a valid/ready interface and assembles 16-bit instruction words (4-bit opcode, 8-bit func field, remaining operand bits).
- Writes each word sequentially into instruction memory starting at address 0.
- Holds the CPU in reset until the full program is stored, then releases it.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/instr_loader.sv | 126 ++++++++++++
 tb/tb_instr_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout and loader states.
// Imported by the boot loader and the core.
package cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int FUNC_MSB = 11;
  localparam int FUNC_LSB = 4;

  typedef enum logic [2:0] {
    LD_HI    = 3'd0,
    LD_LO    = 3'd1,
    LD_FLUSH = 3'd2,
    LD_DONE  = 3'd3,
    LD_ERR   = 3'd4
  } ld_state_e;

  function automatic logic [3:0] opcode_of(
    input logic [INSTR_W-1:0] w
  );
    return w[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [7:0] func_of(
    input logic [INSTR_W-1:0] w
  );
    return w[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

// File: rtl/instr_loader.sv
// Boot loader: packs a byte stream into 16-bit words, writes imem,
// and holds the CPU in reset until the whole program is stored.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  output logic               load_done,
  output logic               load_err,
  output logic [ADDR_W:0]    word_count
);

  localparam logic [ADDR_W:0] WC_MAX = MAX_WORDS;
  localparam logic [ADDR_W:0] WC_ONE = 1;

  ld_state_e          st_q, st_d;
  logic [7:0]         hi_q, hi_d;
  logic [ADDR_W:0]    wc_q, wc_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               hs;

  // Accept bytes only while assembling words and out of reset.
  assign s_ready = rst & ((st_q == LD_HI) | (st_q == LD_LO));
  assign hs      = s_valid & s_ready;

  // Next-state and registered-output logic of the load sequence.
  always_comb begin
    st_d      = st_q;
    hi_d      = hi_q;
    wc_d      = wc_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    unique case (st_q)
      LD_HI: begin
        if (hs) begin
          if (s_last || (wc_q == WC_MAX)) begin
            st_d  = LD_ERR;
            err_d = 1'b1;
          end else begin
            hi_d = s_data;
            st_d = LD_LO;
          end
        end
      end
      LD_LO: begin
        if (hs) begin
          we_d    = 1'b1;
          wdata_d = {hi_q, s_data};
          addr_d  = wc_q[ADDR_W-1:0];
          wc_d    = wc_q + WC_ONE;
          st_d    = s_last ? LD_FLUSH : LD_HI;
        end
      end
      LD_FLUSH: begin
        st_d      = LD_DONE;
        done_d    = 1'b1;
        cpu_rst_d = 1'b0;
      end
      LD_DONE: begin
        st_d = LD_DONE;
      end
      LD_ERR: begin
        st_d = LD_ERR;
      end
      default: begin
        st_d  = LD_ERR;
        err_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q      <= LD_HI;
      hi_q      <= '0;
      wc_q      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      hi_q      <= hi_d;
      wc_q      <= wc_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: random and directed byte streams
// compared with a word-level reference model.
module tb_instr_loader;

  localparam int AW   = 12;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  instr_loader #(
    .INSTR_W(16),
    .ADDR_W(AW),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst),
    .load_done(load_done),
    .load_err(load_err),
    .word_count(word_count)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
    int            c;
  } wr_t;

  wr_t obs[$];
  always @(negedge clk)
    if (imem_we) obs.push_back('{imem_addr, imem_wdata, cyc});

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]    pb[$];
  bit            pl[$];
  int            lo_cyc[$];
  logic [AW-1:0] ea[$];
  logic [15:0]   ed[$];
  int            e_out;
  int            e_nacc;

  // Reference: walk the byte list pairwise at word level.
  // e_out: 0 still loading, 1 done, 2 error.
  task automatic model();
    int nw;
    nw = 0;
    ea.delete();
    ed.delete();
    e_out = 0;
    e_nacc = 0;
    for (int i = 0; i < pb.size(); i++) begin
      e_nacc++;
      if (i % 2 == 0) begin
        if (pl[i] || nw == MAXW) begin
          e_out = 2;
          break;
        end
      end else begin
        ea.push_back(AW'(nw));
        ed.push_back({pb[i-1], pb[i]});
        nw++;
        if (pl[i]) begin
          e_out = 1;
          break;
        end
      end
    end
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    @(negedge clk);
    if (check) begin
      chk("rst_ready", 32'(s_ready), 32'd0);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", 32'(imem_wdata), 32'd0);
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_err", 32'(load_err), 32'd0);
      chk("rst_wc", 32'(word_count), 32'd0);
    end
    obs.delete();
    lo_cyc.delete();
    rst = 1'b1;
  endtask

  task automatic drive(input int n, input int max_gap);
    int g;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(max_gap, 0);
      repeat (g) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data = 8'($urandom);
        s_last = 1'($urandom);
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data = pb[i];
      s_last = pl[i];
      #1;
      for (int w = 0; w < 20 && !s_ready; w++) begin
        @(negedge clk);
        #1;
      end
      chk("hs_ready", 32'(s_ready), 32'd1);
      if (!s_ready) break;
      if (i % 2 == 1) lo_cyc.push_back(cyc);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic run_prog(input int max_gap);
    model();
    do_reset(1'b0);
    drive(e_nacc, max_gap);
    if (e_out == 1) chk("done_early", 32'(load_done), 32'd0);
    if (e_out == 2) chk("err_now", 32'(load_err), 32'd1);
    @(negedge clk);
    if (e_out == 1) begin
      chk("done_t2", 32'(load_done), 32'd1);
      chk("cpu_rst_t2", 32'(cpu_rst), 32'd0);
    end
    repeat (3) @(negedge clk);
    chk("n_writes", 32'(obs.size()), 32'(ea.size()));
    for (int i = 0; i < obs.size() && i < ea.size(); i++) begin
      chk("wr_addr", 32'(obs[i].a), 32'(ea[i]));
      chk("wr_data", 32'(obs[i].d), 32'(ed[i]));
      if (i < lo_cyc.size())
        chk("wr_lat", 32'(obs[i].c), 32'(lo_cyc[i] + 1));
    end
    chk("done", 32'(load_done), 32'(e_out == 1));
    chk("err", 32'(load_err), 32'(e_out == 2));
    chk("cpu_rst", 32'(cpu_rst), 32'(e_out != 1));
    chk("ready", 32'(s_ready), 32'(e_out == 0));
    chk("wc", 32'(word_count), 32'(ea.size()));
    chk("excl", 32'(load_done & load_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int len;
    int nobs;
    do_reset(1'b1);

    pb = '{8'h12, 8'h34, 8'h56, 8'h78};
    pl = '{0, 0, 0, 1};
    run_prog(0);

    nobs = obs.size();
    repeat (5) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = 8'hFF;
      s_last = 1'b1;
      #1;
      chk("done_ready", 32'(s_ready), 32'd0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
    @(negedge clk);
    chk("done_nowr", 32'(obs.size()), 32'(nobs));
    chk("done_wc", 32'(word_count), 32'd2);
    chk("done_addr", 32'(imem_addr), 32'd1);
    chk("done_wdata", 32'(imem_wdata), 32'h5678);
    chk("done_hold", 32'(load_done), 32'd1);
    chk("done_cpu", 32'(cpu_rst), 32'd0);

    run_prog(3);

    pb = '{8'hAB, 8'hCD, 8'hEF};
    pl = '{0, 0, 1};
    run_prog(0);

    pb.delete();
    pl.delete();
    for (int i = 0; i < 10; i++) begin
      pb.push_back(8'(i * 17 + 1));
      pl.push_back(1'b0);
    end
    run_prog(1);

    do_reset(1'b0);
    pb = '{8'h11, 8'h22, 8'h33};
    pl = '{0, 0, 0};
    drive(3, 0);
    pb = '{8'h44, 8'h55};
    pl = '{0, 1};
    run_prog(0);

    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(11, 1);
      pb.delete();
      pl.delete();
      for (int i = 0; i < len; i++) begin
        pb.push_back(8'($urandom));
        if (i == len - 1) pl.push_back($urandom_range(4, 0) != 0);
        else pl.push_back($urandom_range(15, 0) == 0);
      end
      run_prog($urandom_range(3, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
